// File: rtl/cdb_arbiter_if.sv
// Result-request and CDB broadcast bundle between the functional units and cdb_arbiter.
// master = functional-unit side, slave = arbiter side.
interface cdb_arbiter_if #(
  parameter int NUM_REQ  = 3,
  parameter int ROB_ID_W = 4
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*ROB_ID_W-1:0] req_rob_id;
  logic [NUM_REQ*32-1:0]       req_value;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        cdb_valid;
  logic [ROB_ID_W-1:0]         cdb_rob_id;
  logic [31:0]                 cdb_value;
  logic [SRC_W-1:0]            cdb_src;

  modport master (
    output req_valid, req_rob_id, req_value,
    input  req_ready, cdb_valid, cdb_rob_id, cdb_value, cdb_src
  );

  modport slave (
    input  req_valid, req_rob_id, req_value,
    output req_ready, cdb_valid, cdb_rob_id, cdb_value, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB writeback arbiter: one private result FIFO per unit, one registered broadcast per cycle.
// Define CDB_ARB_STATS_EN to add the count_grants / count_conflicts statistics outputs.
module cdb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ROB_ID_W   = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        clear,
`ifdef CDB_ARB_STATS_EN
  output logic [15:0] count_grants,
  output logic [15:0] count_conflicts,
`endif
  cdb_arbiter_if.slave bus
);

  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_REQ - 1);

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [31:0]         value;
  } entry_t;

  entry_t           mem   [NUM_REQ][FIFO_DEPTH];
  logic [PTR_W-1:0] head  [NUM_REQ];
  logic [PTR_W-1:0] tail  [NUM_REQ];
  logic [CNT_W-1:0] count [NUM_REQ];
  logic [SRC_W-1:0] rr_ptr;

  logic [NUM_REQ-1:0] nonempty;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic               active;
  logic               found;
  logic               issue;
  logic [SRC_W-1:0]   grant;
  logic [SRC_W-1:0]   rr_next;
  entry_t             head_entry;

  logic                cdb_valid_q;
  logic [ROB_ID_W-1:0] cdb_rob_id_q;
  logic [31:0]         cdb_value_q;
  logic [SRC_W-1:0]    cdb_src_q;

  assign active = rdy_in && !clear;

  // Ready looks only at registered occupancy, so a unit never sees a slot freed by this cycle's pop.
  always_comb begin
    nonempty = '0;
    ready    = '0;
    push     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      nonempty[k] = (count[k] != '0);
      ready[k]    = active && (count[k] < FULL_CNT);
      push[k]     = ready[k] && bus.req_valid[k];
    end
  end

  // NOTE: every variable written here gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic [SRC_W-1:0] idx;
    found = 1'b0;
    grant = '0;
    idx   = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        grant = idx;
      end
      idx = (idx == LAST_SRC) ? '0 : idx + SRC_W'(1);
    end
    rr_next = (grant == LAST_SRC) ? '0 : grant + SRC_W'(1);
  end

  assign issue      = active && found;
  assign head_entry = mem[grant][head[grant]];

  always_comb begin
    pop = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pop[k] = issue && (grant == SRC_W'(k));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        head[k]  <= '0;
        tail[k]  <= '0;
        count[k] <= '0;
      end
    end else if (rdy_in) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (clear) begin
          head[k]  <= '0;
          tail[k]  <= '0;
          count[k] <= '0;
        end else begin
          if (push[k]) tail[k] <= tail[k] + PTR_W'(1);
          if (pop[k])  head[k] <= head[k] + PTR_W'(1);
          if (push[k] && !pop[k])      count[k] <= count[k] + CNT_W'(1);
          else if (pop[k] && !push[k]) count[k] <= count[k] - CNT_W'(1);
        end
      end
    end
  end

  // NOTE: the storage array has no reset; head/tail/count alone decide which words are live.
  always_ff @(posedge clk_in) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (push[k]) begin
        mem[k][tail[k]] <= {bus.req_rob_id[k*ROB_ID_W +: ROB_ID_W], bus.req_value[k*32 +: 32]};
      end
    end
  end

  // Data outputs keep the last broadcast when nothing issues; only cdb_valid drops.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_value_q  <= '0;
      cdb_src_q    <= '0;
      rr_ptr       <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        cdb_valid_q <= 1'b0;
        rr_ptr      <= '0;
      end else if (issue) begin
        cdb_valid_q  <= 1'b1;
        cdb_rob_id_q <= head_entry.rob_id;
        cdb_value_q  <= head_entry.value;
        cdb_src_q    <= grant;
        rr_ptr       <= rr_next;
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_rob_id = cdb_rob_id_q;
  assign bus.cdb_value  = cdb_value_q;
  assign bus.cdb_src    = cdb_src_q;

`ifdef CDB_ARB_STATS_EN
  logic conflict;
  assign conflict = ($countones(nonempty) > 1);

  // Counters survive clear and wrap silently at 16 bits.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count_grants    <= '0;
      count_conflicts <= '0;
    end else if (issue) begin
      count_grants <= count_grants + 16'd1;
      if (conflict) count_conflicts <= count_conflicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, multi-cycle corner sequences,
// and random traffic compared against a queue-based reference model.
module tb_cdb_arbiter;
  localparam int NUM_REQ    = 3;
  localparam int ROB_ID_W   = 4;
  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic [3:0]  rob;
    logic [31:0] val;
  } ent_t;

  typedef struct {
    logic        rdy;
    logic        clr;
    logic [2:0]  valid;
    logic [11:0] rob;
    logic [95:0] val;
    logic [2:0]  e_ready;
    logic        e_valid;
    logic [3:0]  e_rob;
    logic [31:0] e_val;
    logic [1:0]  e_src;
  } vec_t;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  logic rdy_in   = 1'b1;
  logic clear    = 1'b0;
  int   n_tests  = 0;
  int   n_fail   = 0;

  cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .ROB_ID_W(ROB_ID_W)) bus ();

`ifdef CDB_ARB_STATS_EN
  logic [15:0] count_grants;
  logic [15:0] count_conflicts;
`endif

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .ROB_ID_W(ROB_ID_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .rdy_in          (rdy_in),
    .clear           (clear),
`ifdef CDB_ARB_STATS_EN
    .count_grants    (count_grants),
    .count_conflicts (count_conflicts),
`endif
    .bus             (bus)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: one queue per unit plus the broadcast register and round-robin start.
  ent_t        mq [NUM_REQ][$];
  int          m_rr;
  logic        m_valid;
  logic [3:0]  m_rob;
  logic [31:0] m_val;
  logic [1:0]  m_src;
  int          m_grants;
  int          m_conf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_REQ; k++) mq[k].delete();
    m_rr = 0; m_valid = 1'b0; m_rob = '0; m_val = '0; m_src = '0;
    m_grants = 0; m_conf = 0;
  endtask

  function automatic logic [2:0] model_ready();
    logic [2:0] r;
    for (int k = 0; k < NUM_REQ; k++) r[k] = rdy_in && !clear && (mq[k].size() < FIFO_DEPTH);
    return r;
  endfunction

  // Applies one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    int g;
    int busy;
    ent_t e;
    logic [2:0] acc;
    if (!rdy_in) return;
    if (clear) begin
      for (int k = 0; k < NUM_REQ; k++) mq[k].delete();
      m_valid = 1'b0;
      m_rr = 0;
      return;
    end
    g = -1;
    busy = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      acc[k] = bus.req_valid[k] && (mq[k].size() < FIFO_DEPTH);
      if (mq[k].size() > 0) busy++;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g < 0 && mq[(m_rr + i) % NUM_REQ].size() > 0) g = (m_rr + i) % NUM_REQ;
    end
    if (g >= 0) begin
      e = mq[g].pop_front();
      m_valid = 1'b1; m_rob = e.rob; m_val = e.val; m_src = 2'(g);
      m_rr = (g + 1) % NUM_REQ;
      m_grants++;
      if (busy > 1) m_conf++;
    end else begin
      m_valid = 1'b0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (acc[k]) mq[k].push_back({bus.req_rob_id[k*4 +: 4], bus.req_value[k*32 +: 32]});
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " cdb_valid"},  bus.cdb_valid,  m_valid);
    check({tag, " cdb_rob_id"}, bus.cdb_rob_id, m_rob);
    check({tag, " cdb_value"},  bus.cdb_value,  m_val);
    check({tag, " cdb_src"},    bus.cdb_src,    m_src);
`ifdef CDB_ARB_STATS_EN
    check({tag, " count_grants"},    count_grants,    16'(m_grants));
    check({tag, " count_conflicts"}, count_conflicts, 16'(m_conf));
`endif
  endtask

  task automatic drive(input logic r, input logic c, input logic [2:0] v,
                       input logic [11:0] ids, input logic [95:0] vals);
    rdy_in = r; clear = c;
    bus.req_valid = v; bus.req_rob_id = ids; bus.req_value = vals;
  endtask

  // One clock: check ready before the edge, advance the model, check the CDB after the edge.
  task automatic cycle(input string tag, output logic [2:0] seen);
    #1;
    seen = bus.req_ready;
    check({tag, " req_ready"}, bus.req_ready, model_ready());
    @(posedge clk_in);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic idle(input string tag, input int n);
    logic [2:0] s;
    drive(1'b1, 1'b0, 3'b000, 12'h0, 96'h0);
    repeat (n) cycle(tag, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [14];
    logic [2:0] seen;
    logic [3:0] nid [3];
    int         acc0;

    vecs[0]  = '{1'b1, 1'b0, 3'b111, 12'h321, {32'hA2, 32'hA1, 32'hA0},     3'b111, 1'b0, 4'h0, 32'h0,    2'd0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 12'h000, 96'h0,                        3'b111, 1'b1, 4'h1, 32'hA0,   2'd0};
    vecs[2]  = '{1'b1, 1'b0, 3'b000, 12'h000, 96'h0,                        3'b111, 1'b1, 4'h2, 32'hA1,   2'd1};
    vecs[3]  = '{1'b1, 1'b0, 3'b000, 12'h000, 96'h0,                        3'b111, 1'b1, 4'h3, 32'hA2,   2'd2};
    vecs[4]  = '{1'b1, 1'b0, 3'b000, 12'h000, 96'h0,                        3'b111, 1'b0, 4'h3, 32'hA2,   2'd2};
    vecs[5]  = '{1'b1, 1'b0, 3'b010, 12'h050, {32'h0, 32'h1234, 32'h0},     3'b111, 1'b0, 4'h3, 32'hA2,   2'd2};
    vecs[6]  = '{1'b1, 1'b0, 3'b000, 12'h000, 96'h0,                        3'b111, 1'b1, 4'h5, 32'h1234, 2'd1};
    vecs[7]  = '{1'b1, 1'b0, 3'b000, 12'h000, 96'h0,                        3'b111, 1'b0, 4'h5, 32'h1234, 2'd1};
    vecs[8]  = '{1'b0, 1'b0, 3'b001, 12'h007, {32'h0, 32'h0, 32'h77},       3'b000, 1'b0, 4'h5, 32'h1234, 2'd1};
    vecs[9]  = '{1'b1, 1'b0, 3'b000, 12'h000, 96'h0,                        3'b111, 1'b0, 4'h5, 32'h1234, 2'd1};
    vecs[10] = '{1'b1, 1'b0, 3'b100, 12'h900, {32'h99, 32'h0, 32'h0},       3'b111, 1'b0, 4'h5, 32'h1234, 2'd1};
    vecs[11] = '{1'b0, 1'b1, 3'b000, 12'h000, 96'h0,                        3'b000, 1'b0, 4'h5, 32'h1234, 2'd1};
    vecs[12] = '{1'b1, 1'b1, 3'b000, 12'h000, 96'h0,                        3'b000, 1'b0, 4'h5, 32'h1234, 2'd1};
    vecs[13] = '{1'b1, 1'b0, 3'b000, 12'h000, 96'h0,                        3'b111, 1'b0, 4'h5, 32'h1234, 2'd1};

    // Reset held for three edges, then released.
    model_reset();
    drive(1'b1, 1'b0, 3'b000, 12'h0, 96'h0);
    repeat (3) @(posedge clk_in);
    #1;
    check("reset cdb_valid held", bus.cdb_valid, 1'b0);
    rst_n_in = 1'b1;
    #1;
    check("reset req_ready",  bus.req_ready,  3'b111);
    check("reset cdb_valid",  bus.cdb_valid,  1'b0);
    check("reset cdb_rob_id", bus.cdb_rob_id, 4'h0);
    check("reset cdb_value",  bus.cdb_value,  32'h0);
    check("reset cdb_src",    bus.cdb_src,    2'd0);

    // Directed vectors: collision, single unit, stall-ignored push, clear while stalled, flush.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rdy, vecs[i].clr, vecs[i].valid, vecs[i].rob, vecs[i].val);
      #1;
      check($sformatf("vec%0d req_ready", i), bus.req_ready, vecs[i].e_ready);
      @(posedge clk_in);
      model_edge();
      #1;
      check($sformatf("vec%0d cdb_valid", i),  bus.cdb_valid,  vecs[i].e_valid);
      check($sformatf("vec%0d cdb_rob_id", i), bus.cdb_rob_id, vecs[i].e_rob);
      check($sformatf("vec%0d cdb_value", i),  bus.cdb_value,  vecs[i].e_val);
      check($sformatf("vec%0d cdb_src", i),    bus.cdb_src,    vecs[i].e_src);
`ifdef CDB_ARB_STATS_EN
      if (i == 4) begin
        check("collision count_grants",    count_grants,    16'd3);
        check("collision count_conflicts", count_conflicts, 16'd2);
      end
`endif
    end

    // Backpressure: every unit always has a result; units hold requests until accepted.
    nid[0] = 4'd0; nid[1] = 4'd5; nid[2] = 4'd10;
    acc0 = 0;
    for (int c = 0; c < 30; c++) begin
      drive(1'b1, 1'b0, 3'b111, {nid[2], nid[1], nid[0]},
            {32'h200 + 32'(nid[2]), 32'h100 + 32'(nid[1]), 32'(nid[0])});
      cycle("backpressure", seen);
      if (c == 3) check("backpressure ready0 low when full", seen[0], 1'b0);
      if (c >= 9 && seen[0]) acc0++;
      for (int k = 0; k < 3; k++) if (seen[k]) nid[k] = nid[k] + 4'd1;
    end
    check("backpressure unit0 accepts in 21 cycles", acc0, 7);
    idle("drain", 10);

    // Flush with four entries queued and a same-cycle push on unit 2.
    drive(1'b1, 1'b0, 3'b111, 12'h876, {32'h8, 32'h7, 32'h6});
    cycle("flush fill", seen);
    drive(1'b1, 1'b0, 3'b110, 12'hBA0, {32'hB, 32'hA, 32'h0});
    cycle("flush fill", seen);
    drive(1'b1, 1'b1, 3'b100, 12'hE00, {32'hE, 64'h0});
    cycle("flush", seen);
    check("flush cdb_valid", bus.cdb_valid, 1'b0);
    idle("post flush", 3);
    drive(1'b1, 1'b0, 3'b100, 12'hC00, {32'hCCCC, 64'h0});
    cycle("post flush push", seen);
    drive(1'b1, 1'b0, 3'b000, 12'h0, 96'h0);
    cycle("post flush push", seen);
    check("post flush broadcast valid", bus.cdb_valid,  1'b1);
    check("post flush broadcast src",   bus.cdb_src,    2'd2);
    check("post flush broadcast rob",   bus.cdb_rob_id, 4'hC);

    // Stall with entries pending; order must resume from the saved pointer.
    drive(1'b1, 1'b0, 3'b111, 12'h321, {32'h33, 32'h22, 32'h11});
    cycle("stall fill", seen);
    drive(1'b1, 1'b0, 3'b000, 12'h0, 96'h0);
    cycle("stall fill", seen);
    check("stall first src", bus.cdb_src, 2'd0);
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, 1'b0, 3'b111, 12'hFFF, {3{32'hFFFF_FFFF}});
      cycle("stall", seen);
      check("stall req_ready", seen, 3'b000);
      check("stall cdb_valid held", bus.cdb_valid, 1'b1);
      check("stall cdb_src held", bus.cdb_src, 2'd0);
    end
    drive(1'b1, 1'b0, 3'b000, 12'h0, 96'h0);
    cycle("resume", seen);
    check("resume src 1", bus.cdb_src, 2'd1);
    check("resume rob 2", bus.cdb_rob_id, 4'h2);
    cycle("resume", seen);
    check("resume src 2", bus.cdb_src, 2'd2);
    check("resume rob 3", bus.cdb_rob_id, 4'h3);

    // Reset pulse between edges discards everything immediately.
    drive(1'b1, 1'b0, 3'b111, 12'h456, {32'h6, 32'h5, 32'h4});
    cycle("pre reset", seen);
    drive(1'b1, 1'b0, 3'b000, 12'h0, 96'h0);
    cycle("pre reset", seen);
    #2 rst_n_in = 1'b0;
    #1;
    check("mid reset cdb_valid",  bus.cdb_valid,  1'b0);
    check("mid reset cdb_rob_id", bus.cdb_rob_id, 4'h0);
    check("mid reset cdb_value",  bus.cdb_value,  32'h0);
    check("mid reset cdb_src",    bus.cdb_src,    2'd0);
    check("mid reset req_ready",  bus.req_ready,  3'b111);
    #2 rst_n_in = 1'b1;
    model_reset();
    idle("after reset", 3);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 5, 3'($urandom),
            12'($urandom), {$urandom, $urandom, $urandom});
      cycle("random", seen);
    end
    idle("final drain", 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
